sdram_line_sequencer: RTL and testbench

//  Cache-side master for the Gowin SDRAM_Controller_HS_Top user interface. Converts one
//  8-word (256-bit) cache-line read or write request into ACTIVE + READ/WRITE burst

---
 rtl/sdram_pkg.sv | 33 +++
 rtl/sdram_line_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_sdram_line_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the cache-line SDRAM sequencer.
//   - Command codes for the Gowin SDRAM_Controller_HS_Top user interface
//   - SDRAM geometry (bank/row/column widths) and line size
//   - state_e: sequencer FSM states
package sdram_pkg;

  localparam logic [2:0] CMD_ACTIVE = 3'b011;
  localparam logic [2:0] CMD_WRITE  = 3'b100;
  localparam logic [2:0] CMD_READ   = 3'b101;

  localparam int unsigned SDRAM_BANKS_WIDTH = 2;
  localparam int unsigned SDRAM_ROWS_WIDTH  = 11;
  localparam int unsigned SDRAM_COLS_WIDTH  = 8;
  localparam int unsigned SDRC_ADDR_WIDTH   =
      SDRAM_BANKS_WIDTH + SDRAM_ROWS_WIDTH + SDRAM_COLS_WIDTH;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_BITS  = 32;
  localparam int unsigned LINE_BITS  = LINE_WORDS * WORD_BITS;

  typedef enum logic [3:0] {
    StInit,
    StIdle,
    StAct,
    StActWait,
    StWrBurst,
    StWrRecover,
    StRdCmd,
    StRdWait,
    StRdCapture
  } state_e;

endpackage

// File: rtl/sdram_line_sequencer.sv
// Cache-side master for the Gowin SDRAM_Controller_HS_Top user interface.
// Turns one 8-word cache-line request into ACTIVE + WRITE/READ burst commands with
// auto-precharge, spacing them by the controller's timing gaps.
//
// Ports:
//   clk, rst               clock (also the controller clock), async active-high reset
//   req_valid/req_ready    request handshake; req_write selects write (1) or read (0)
//   req_addr               byte address, low 5 bits ignored (line aligned)
//   req_wdata              write line, word i = req_wdata[32*i +: 32]
//   resp_valid             1-cycle pulse when a read completes or a write retires
//   resp_rdata             last read line, held until the next read completes
//   error                  sticky: an expected sdrc_cmd_ack was low
//   sdrc_*                 controller user interface (commands, address, data, ack)
module sdram_line_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 23,
  parameter int unsigned ACT_TO_CMD  = 4,
  parameter int unsigned RD_LATENCY  = 5,
  parameter int unsigned WR_RECOVERY = 4,
  parameter int unsigned ACK_DELAY   = 2
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [LINE_BITS-1:0]       req_wdata,
  output logic                       resp_valid,
  output logic [LINE_BITS-1:0]       resp_rdata,
  output logic                       error,

  input  logic                       sdrc_init_done,
  output logic                       sdrc_cmd_en,
  output logic [2:0]                 sdrc_cmd,
  output logic                       sdrc_precharge_ctrl,
  output logic                       sdrc_power_down,
  output logic                       sdrc_selfrefresh,
  output logic [SDRC_ADDR_WIDTH-1:0] sdrc_addr,
  output logic [3:0]                 sdrc_dqm,
  output logic [WORD_BITS-1:0]       sdrc_data,
  output logic [7:0]                 sdrc_data_len,
  input  logic [WORD_BITS-1:0]       sdrc_data_out,
  input  logic                       sdrc_cmd_ack
);

  localparam int unsigned MAX_T1 = (ACT_TO_CMD > RD_LATENCY) ? ACT_TO_CMD : RD_LATENCY;
  localparam int unsigned MAX_T  = (MAX_T1 > WR_RECOVERY) ? MAX_T1 : WR_RECOVERY;
  localparam int unsigned CNT_W  = $clog2(MAX_T + 1);

  // The ACT_WAIT counter starts at ACT_TO_CMD-1 on the edge ending ACT, so the edge
  // lying ACK_DELAY cycles after the ACT edge is the one where it equals this value.
  localparam logic [CNT_W-1:0] ACK_CHECK_CNT = CNT_W'(ACT_TO_CMD - ACK_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  if (ACT_TO_CMD < 1 || RD_LATENCY < 1 || WR_RECOVERY < 1 || ACK_DELAY < 1 ||
      ACK_DELAY >= ACT_TO_CMD) begin : g_bad_timing
    $error("sdram_line_sequencer: timing parameters must be >= 1 and ACK_DELAY < ACT_TO_CMD");
  end
  if (ADDR_WIDTH != SDRC_ADDR_WIDTH + 2) begin : g_bad_addr
    $error("sdram_line_sequencer: ADDR_WIDTH must equal controller word address width + 2");
  end

  state_e                     state;
  logic [CNT_W-1:0]           cnt;
  logic [2:0]                 widx;
  logic                       write_q;
  logic [SDRC_ADDR_WIDTH-1:0] line_q;
  // Holds the write line (drained from the bottom) or collects the read line (filled
  // from the top), so a single register serves both directions.
  logic [LINE_BITS-1:0]       line_sr;

  logic [SDRC_ADDR_WIDTH-1:0] row_addr;
  logic [LINE_BITS-1:0]       line_shift_in;
  logic                       unused_addr_bits;

  assign sdrc_precharge_ctrl = 1'b1;
  assign sdrc_power_down     = 1'b0;
  assign sdrc_selfrefresh    = 1'b0;
  assign sdrc_dqm            = 4'b0000;
  assign sdrc_data_len       = 8'(LINE_WORDS - 1);

  assign row_addr      = {line_q[SDRC_ADDR_WIDTH-1:SDRAM_COLS_WIDTH], {SDRAM_COLS_WIDTH{1'b0}}};
  assign line_shift_in = {sdrc_data_out, line_sr[LINE_BITS-1:WORD_BITS]};

  assign unused_addr_bits = ^req_addr[4:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StInit;
      cnt         <= '0;
      widx        <= '0;
      write_q     <= 1'b0;
      line_q      <= '0;
      line_sr     <= '0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      error       <= 1'b0;
      sdrc_cmd_en <= 1'b0;
      sdrc_cmd    <= 3'b000;
      sdrc_addr   <= '0;
      sdrc_data   <= '0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      resp_valid  <= 1'b0;
      sdrc_cmd_en <= 1'b0;
      sdrc_cmd    <= 3'b000;

      unique case (state)
        StInit: begin
          if (sdrc_init_done) begin
            state     <= StIdle;
            req_ready <= 1'b1;
          end
        end

        StIdle: begin
          if (req_valid) begin
            line_q      <= {req_addr[ADDR_WIDTH-1:5], 3'b000};
            write_q     <= req_write;
            line_sr     <= req_wdata;
            req_ready   <= 1'b0;
            state       <= StAct;
            sdrc_cmd_en <= 1'b1;
            sdrc_cmd    <= CMD_ACTIVE;
            sdrc_addr   <= {req_addr[ADDR_WIDTH-1:SDRAM_COLS_WIDTH+2], {SDRAM_COLS_WIDTH{1'b0}}};
          end
        end

        StAct: begin
          state <= StActWait;
          cnt   <= CNT_W'(ACT_TO_CMD - 1);
        end

        StActWait: begin
          if (cnt == ACK_CHECK_CNT && !sdrc_cmd_ack) begin
            error <= 1'b1;
          end
          if (cnt == CNT_ONE) begin
            sdrc_cmd_en <= 1'b1;
            sdrc_addr   <= line_q;
            if (write_q) begin
              state     <= StWrBurst;
              sdrc_cmd  <= CMD_WRITE;
              sdrc_data <= line_sr[WORD_BITS-1:0];
              line_sr   <= {{WORD_BITS{1'b0}}, line_sr[LINE_BITS-1:WORD_BITS]};
              widx      <= '0;
            end else begin
              state    <= StRdCmd;
              sdrc_cmd <= CMD_READ;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        StWrBurst: begin
          if (widx == 3'd7) begin
            state     <= StWrRecover;
            cnt       <= CNT_W'(WR_RECOVERY);
            sdrc_data <= '0;
          end else begin
            widx      <= widx + 3'd1;
            sdrc_data <= line_sr[WORD_BITS-1:0];
            line_sr   <= {{WORD_BITS{1'b0}}, line_sr[LINE_BITS-1:WORD_BITS]};
          end
        end

        StWrRecover: begin
          if (cnt == CNT_ONE) begin
            if (!sdrc_cmd_ack) begin
              error <= 1'b1;
            end
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
            state      <= StIdle;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        StRdCmd: begin
          widx <= '0;
          if (RD_LATENCY == 1) begin
            state <= StRdCapture;
          end else begin
            state <= StRdWait;
            cnt   <= CNT_W'(RD_LATENCY - 1);
          end
        end

        StRdWait: begin
          if (cnt == CNT_ONE) begin
            state <= StRdCapture;
            widx  <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        StRdCapture: begin
          line_sr <= line_shift_in;
          widx    <= widx + 3'd1;
          if (widx == 3'd7) begin
            // Publish the whole line at once so resp_rdata never shows a partial line.
            resp_rdata <= line_shift_in;
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
            state      <= StIdle;
          end
        end

        default: begin
          state     <= StInit;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_line_sequencer.sv
// Directed bench for sdram_line_sequencer with a small behavioural stand-in for the
// SDRAM controller (command decode, burst write/read memory, fixed read latency).
module tb_sdram_line_sequencer;

  localparam int ACT_TO_CMD  = 4;
  localparam int RD_LATENCY  = 5;
  localparam int WR_LAT_EXP  = 16;  // ACT 1 + wait 3 + burst 8 + recovery 4
  localparam int RD_LAT_EXP  = 17;  // ACT 1 + wait 3 + READ 1 + wait 4 + capture 8

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [22:0]  req_addr;
  logic [255:0] req_wdata;
  logic         resp_valid;
  logic [255:0] resp_rdata;
  logic         error;
  logic         sdrc_init_done;
  logic         sdrc_cmd_en;
  logic [2:0]   sdrc_cmd;
  logic         sdrc_precharge_ctrl;
  logic         sdrc_power_down;
  logic         sdrc_selfrefresh;
  logic [20:0]  sdrc_addr;
  logic [3:0]   sdrc_dqm;
  logic [31:0]  sdrc_data;
  logic [7:0]   sdrc_data_len;
  logic [31:0]  sdrc_data_out;
  logic         sdrc_cmd_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_line_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_rdata          (resp_rdata),
    .error               (error),
    .sdrc_init_done      (sdrc_init_done),
    .sdrc_cmd_en         (sdrc_cmd_en),
    .sdrc_cmd            (sdrc_cmd),
    .sdrc_precharge_ctrl (sdrc_precharge_ctrl),
    .sdrc_power_down     (sdrc_power_down),
    .sdrc_selfrefresh    (sdrc_selfrefresh),
    .sdrc_addr           (sdrc_addr),
    .sdrc_dqm            (sdrc_dqm),
    .sdrc_data           (sdrc_data),
    .sdrc_data_len       (sdrc_data_len),
    .sdrc_data_out       (sdrc_data_out),
    .sdrc_cmd_ack        (sdrc_cmd_ack)
  );

  // ---------------- controller stand-in (evaluated mid-cycle) ----------------
  logic [31:0] mem [int];
  logic        ack_ok = 1'b1;
  logic [20:0] exp_line = '0;
  int          neg_cnt = 0;
  int          act_at = 0;
  logic        prev_en = 1'b0;
  int          rd_phase = 0;
  int          wr_phase = 0;
  int          rd_base = 0;
  int          wr_base = 0;

  assign sdrc_cmd_ack = ack_ok;

  always @(negedge clk) begin
    neg_cnt++;
    if (rst) begin
      rd_phase      = 0;
      wr_phase      = 0;
      prev_en       = 1'b0;
      sdrc_data_out = 32'hdead_beef;
    end else begin
      if (wr_phase != 0) begin
        mem[wr_base + wr_phase] = sdrc_data;
        wr_phase = (wr_phase == 7) ? 0 : wr_phase + 1;
      end
      if (rd_phase != 0) begin
        if (rd_phase >= RD_LATENCY && rd_phase <= RD_LATENCY + 7)
          sdrc_data_out = mem.exists(rd_base + rd_phase - RD_LATENCY) ?
                          mem[rd_base + rd_phase - RD_LATENCY] : 32'h0;
        else
          sdrc_data_out = 32'hdead_beef;
        rd_phase = (rd_phase == RD_LATENCY + 7) ? 0 : rd_phase + 1;
      end else begin
        sdrc_data_out = 32'hdead_beef;
      end
      if (sdrc_cmd_en) begin
        checks++;
        if (prev_en) begin
          errors++;
          $display("FAIL cmd_en_consecutive: cmd_en high two cycles in a row at cycle %0d", neg_cnt);
        end
        if (sdrc_cmd == 3'b011) begin
          act_at = neg_cnt;
          checks++;
          if (sdrc_addr !== {exp_line[20:8], 8'h00}) begin
            errors++;
            $display("FAIL act_addr: got %h expected %h", sdrc_addr, {exp_line[20:8], 8'h00});
          end
        end else if (sdrc_cmd == 3'b100 || sdrc_cmd == 3'b101) begin
          checks += 2;
          if (neg_cnt - act_at !== ACT_TO_CMD) begin
            errors++;
            $display("FAIL act_to_cmd_gap: got %0d expected %0d", neg_cnt - act_at, ACT_TO_CMD);
          end
          if (sdrc_addr !== exp_line) begin
            errors++;
            $display("FAIL cmd_addr: got %h expected %h", sdrc_addr, exp_line);
          end
          if (sdrc_cmd == 3'b100) begin
            wr_base       = int'(sdrc_addr);
            mem[wr_base]  = sdrc_data;
            wr_phase      = 1;
          end else begin
            rd_base  = int'(sdrc_addr);
            rd_phase = 1;
          end
        end else begin
          checks++;
          errors++;
          $display("FAIL cmd_code: got %b expected an ACTIVE/WRITE/READ code", sdrc_cmd);
        end
      end
      prev_en = sdrc_cmd_en;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [255:0] line_a, line_b, line_c, line_d, line_e;

  // Issues one request and returns at #1 after the edge that raised resp_valid.
  task automatic run_req(input logic wr, input logic [22:0] addr, input logic [255:0] wd,
                         output int acc_cycles, output int lat, output logic to);
    logic acc;
    acc = 1'b0;
    acc_cycles = 0;
    to = 1'b0;
    exp_line = {addr[22:5], 3'b000};
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    while (!acc && acc_cycles < 50) begin
      acc = req_ready;
      @(posedge clk); #1;
      acc_cycles++;
    end
    req_valid = 1'b0;
    if (!acc) to = 1'b1;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) to = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int pulses;
    logic rdy_seen;
    rst = 1'b1; sdrc_init_done = 1'b0; req_valid = 1'b1; req_write = 1'b1;
    req_addr = '0; req_wdata = '0;
    #12;
    checks += 6;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    if (resp_valid !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL rst_resp_err: got %b/%b expected 0/0", resp_valid, error);
    end
    if (sdrc_cmd_en !== 1'b0 || sdrc_cmd !== 3'b000) begin
      errors++; $display("FAIL rst_cmd: got %b/%b expected 0/000", sdrc_cmd_en, sdrc_cmd);
    end
    if (sdrc_addr !== '0 || sdrc_data !== '0 || resp_rdata !== '0) begin
      errors++; $display("FAIL rst_data: addr %h data %h rdata nonzero=%b expected all 0",
                         sdrc_addr, sdrc_data, |resp_rdata);
    end
    if (sdrc_precharge_ctrl !== 1'b1 || sdrc_data_len !== 8'd7) begin
      errors++; $display("FAIL rst_consts: got pc=%b len=%0d expected 1/7",
                         sdrc_precharge_ctrl, sdrc_data_len);
    end
    if (sdrc_power_down !== 1'b0 || sdrc_selfrefresh !== 1'b0 || sdrc_dqm !== 4'b0) begin
      errors++; $display("FAIL rst_zero_consts: got pd=%b sr=%b dqm=%b expected 0",
                         sdrc_power_down, sdrc_selfrefresh, sdrc_dqm);
    end
    @(negedge clk); rst = 1'b0;
    pulses = 0; rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sdrc_cmd_en) pulses++;
      if (req_ready) rdy_seen = 1'b1;
    end
    checks += 2;
    if (pulses !== 0) begin errors++; $display("FAIL init_cmd_en: got %0d pulses expected 0", pulses); end
    if (rdy_seen !== 1'b0) begin errors++; $display("FAIL init_ready: got ready before init_done expected 0"); end
    req_valid = 1'b0;
    sdrc_init_done = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL init_done_ready: got %b expected 1", req_ready); end
    sdrc_init_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL init_drop_ignored: got %b expected 1", req_ready); end
    sdrc_init_done = 1'b1;
  endtask

  task automatic test_write();
    int ac, lat; logic to;
    run_req(1'b1, 23'h000000, line_a, ac, lat, to);
    checks += 3;
    if (to !== 1'b0) begin errors++; $display("FAIL write_timeout: got %b expected 0", to); end
    if (lat !== WR_LAT_EXP) begin errors++; $display("FAIL write_latency: got %0d expected %0d", lat, WR_LAT_EXP); end
    if (error !== 1'b0) begin errors++; $display("FAIL write_error: got %b expected 0", error); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[i] !== line_a[32*i +: 32]) begin
        errors++; $display("FAIL write_word%0d: got %h expected %h", i, mem[i], line_a[32*i +: 32]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL write_resp_pulse: got %b expected 0", resp_valid); end
  endtask

  task automatic test_rows();
    int ac, lat; logic to;
    run_req(1'b1, 23'h000400, line_b, ac, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== WR_LAT_EXP) begin
      errors++; $display("FAIL row1_write: got to=%b lat=%0d expected 0/%0d", to, lat, WR_LAT_EXP);
    end
    @(posedge clk); #1;
    run_req(1'b0, 23'h000000, '0, ac, lat, to);
    checks += 2;
    if (to !== 1'b0 || lat !== RD_LAT_EXP) begin
      errors++; $display("FAIL read_latency: got to=%b lat=%0d expected 0/%0d", to, lat, RD_LAT_EXP);
    end
    if (resp_rdata !== line_a) begin
      errors++; $display("FAIL read_row0: got %h expected %h", resp_rdata, line_a);
    end
    @(posedge clk); #1;
    run_req(1'b0, 23'h000400, '0, ac, lat, to);
    checks++;
    if (to !== 1'b0 || resp_rdata !== line_b) begin
      errors++; $display("FAIL read_row1: got %h expected %h", resp_rdata, line_b);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (resp_rdata !== line_b) begin errors++; $display("FAIL rdata_hold: got %h expected %h", resp_rdata, line_b); end
  endtask

  task automatic test_back_to_back();
    int ac, lat; logic to;
    run_req(1'b1, 23'h000800, line_c, ac, lat, to);
    checks += 2;
    if (to !== 1'b0) begin errors++; $display("FAIL b2b_write: got timeout=%b expected 0", to); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_on_resp: got %b expected 1", req_ready); end
    run_req(1'b0, 23'h000800, '0, ac, lat, to);
    checks += 2;
    if (ac !== 1) begin errors++; $display("FAIL b2b_accept: got %0d cycles expected 1", ac); end
    if (to !== 1'b0 || resp_rdata !== line_c) begin
      errors++; $display("FAIL b2b_read: got %h expected %h", resp_rdata, line_c);
    end
  endtask

  task automatic test_ack_error();
    int ac, lat; logic to;
    @(posedge clk); #1;
    ack_ok = 1'b0;
    run_req(1'b1, 23'h000c00, line_d, ac, lat, to);
    ack_ok = 1'b1;
    checks += 2;
    if (to !== 1'b0 || lat !== WR_LAT_EXP) begin
      errors++; $display("FAIL ackerr_completes: got to=%b lat=%0d expected 0/%0d", to, lat, WR_LAT_EXP);
    end
    if (error !== 1'b1) begin errors++; $display("FAIL ackerr_set: got %b expected 1", error); end
    @(posedge clk); #1;
    run_req(1'b0, 23'h000c00, '0, ac, lat, to);
    checks += 2;
    if (error !== 1'b1) begin errors++; $display("FAIL ackerr_sticky: got %b expected 1", error); end
    if (to !== 1'b0 || resp_rdata !== line_d) begin
      errors++; $display("FAIL ackerr_read: got %h expected %h", resp_rdata, line_d);
    end
  endtask

  task automatic test_reset_mid_burst();
    int ac, lat, n; logic to;
    @(posedge clk); #1;
    exp_line  = {23'h001000 >> 5, 3'b000};
    req_write = 1'b1; req_addr = 23'h001000; req_wdata = line_e; req_valid = 1'b1;
    n = 0;
    while (!(sdrc_cmd_en && sdrc_cmd == 3'b100) && n < 50) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      n++;
    end
    req_valid = 1'b0;
    checks++;
    if (n >= 50) begin errors++; $display("FAIL mid_wait_write: got timeout expected WRITE command"); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sdrc_data !== line_e[96 +: 32]) begin
      errors++; $display("FAIL mid_word3: got %h expected %h", sdrc_data, line_e[96 +: 32]);
    end
    rst = 1'b1; sdrc_init_done = 1'b0;
    #1;
    checks += 3;
    if (sdrc_cmd_en !== 1'b0 || sdrc_data !== '0 || sdrc_addr !== '0) begin
      errors++; $display("FAIL mid_rst_cmd: got en=%b data=%h addr=%h expected 0", sdrc_cmd_en, sdrc_data, sdrc_addr);
    end
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL mid_rst_flags: got rdy=%b rv=%b err=%b expected 0", req_ready, resp_valid, error);
    end
    if (resp_rdata !== '0) begin errors++; $display("FAIL mid_rst_rdata: got %h expected 0", resp_rdata); end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1; sdrc_init_done = 1'b1;
    run_req(1'b1, 23'h001000, line_e, ac, lat, to);
    checks++;
    if (to !== 1'b0 || lat !== WR_LAT_EXP) begin
      errors++; $display("FAIL mid_rewrite: got to=%b lat=%0d expected 0/%0d", to, lat, WR_LAT_EXP);
    end
    run_req(1'b0, 23'h001000, '0, ac, lat, to);
    checks++;
    if (to !== 1'b0 || resp_rdata !== line_e) begin
      errors++; $display("FAIL mid_roundtrip: got %h expected %h", resp_rdata, line_e);
    end
  endtask

  initial begin
    line_a = {32'hdef01234, 32'h456789ab, 32'hcdef0123, 32'h3456789a,
              32'hbcdef012, 32'h23456789, 32'habcdef01, 32'h12345678};
    line_b = ~line_a;
    line_c = line_a ^ {8{32'h5a5a_0000}};
    line_d = {line_a[127:0], line_a[255:128]};
    line_e = line_b ^ {8{32'h0f0f_00ff}};
    test_reset();
    test_write();
    test_rows();
    test_back_to_back();
    test_ack_error();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
